// File: rtl/wb_select_buf.sv
// Writeback-source selector feeding the RegFile write port.
// Picks one of NUM_IN sources, tags the result with its source index and holds
// up to two results in a skid buffer so writeback can stall without losing data.
// An accepted out-of-range select enqueues zero data and raises a sticky error.
module wb_select_buf #(
  parameter int unsigned NUM_IN = 3,
  parameter int unsigned WIDTH  = 8,
  localparam int unsigned SEL_W = $clog2(NUM_IN)
) (
  input  logic                    Clk,
  input  logic                    Reset,
  input  logic [NUM_IN*WIDTH-1:0] In,
  input  logic [SEL_W-1:0]        Sel,
  input  logic                    InValid,
  output logic                    InReady,
  output logic [WIDTH-1:0]        OutData,
  output logic [SEL_W-1:0]        OutSrc,
  output logic                    OutValid,
  input  logic                    OutReady,
  input  logic                    Flush,
  output logic                    Err,
  input  logic                    ErrClr
);

  // Buffer state: head is the oldest entry, tail the second one.
  logic [1:0]       r_count;
  logic [WIDTH-1:0] r_head_data;
  logic [SEL_W-1:0] r_head_src;
  logic [WIDTH-1:0] r_tail_data;
  logic [SEL_W-1:0] r_tail_src;
  logic             r_err;

  logic [1:0]       w_count_nxt;
  logic [WIDTH-1:0] w_head_data_nxt;
  logic [SEL_W-1:0] w_head_src_nxt;
  logic [WIDTH-1:0] w_tail_data_nxt;
  logic [SEL_W-1:0] w_tail_src_nxt;
  logic             w_err_nxt;

  logic [WIDTH-1:0] w_sel_data;
  logic             w_sel_legal;
  logic             w_accept;
  logic             w_pop;

  // Handshake and output view; all derived from registered state only.
  assign InReady  = (r_count != 2'd2);
  assign OutValid = (r_count != 2'd0);
  assign OutData  = OutValid ? r_head_data : '0;
  assign OutSrc   = OutValid ? r_head_src  : '0;
  assign Err      = r_err;

  assign w_accept = InValid & InReady;
  assign w_pop    = OutValid & OutReady;

  // Source mux; an index with no matching source yields zero and is flagged illegal.
  always_comb begin
    w_sel_data  = '0;
    w_sel_legal = 1'b0;
    for (int unsigned k = 0; k < NUM_IN; k++) begin
      if (Sel == SEL_W'(k)) begin
        w_sel_data  = In[k*WIDTH +: WIDTH];
        w_sel_legal = 1'b1;
      end
    end
  end

  // Next-state: FIFO update with flush override, plus sticky error (set beats clear).
  always_comb begin
    w_count_nxt     = r_count;
    w_head_data_nxt = r_head_data;
    w_head_src_nxt  = r_head_src;
    w_tail_data_nxt = r_tail_data;
    w_tail_src_nxt  = r_tail_src;
    w_err_nxt       = r_err;

    if (w_accept && !w_sel_legal) begin
      w_err_nxt = 1'b1;
    end else if (ErrClr) begin
      w_err_nxt = 1'b0;
    end

    if (Flush) begin
      w_count_nxt = 2'd0;
    end else begin
      case ({w_accept, w_pop})
        2'b10: begin
          if (r_count == 2'd0) begin
            w_head_data_nxt = w_sel_data;
            w_head_src_nxt  = Sel;
          end else begin
            w_tail_data_nxt = w_sel_data;
            w_tail_src_nxt  = Sel;
          end
          w_count_nxt = r_count + 2'd1;
        end
        2'b01: begin
          w_head_data_nxt = r_tail_data;
          w_head_src_nxt  = r_tail_src;
          w_count_nxt     = r_count - 2'd1;
        end
        2'b11: begin
          // Accept implies count<2 and pop implies count>0, so count is 1 here:
          // the new entry replaces the departing head.
          w_head_data_nxt = w_sel_data;
          w_head_src_nxt  = Sel;
        end
        default: begin
        end
      endcase
    end
  end

  // State register with synchronous reset.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      r_count     <= 2'd0;
      r_head_data <= '0;
      r_head_src  <= '0;
      r_tail_data <= '0;
      r_tail_src  <= '0;
      r_err       <= 1'b0;
    end else begin
      r_count     <= w_count_nxt;
      r_head_data <= w_head_data_nxt;
      r_head_src  <= w_head_src_nxt;
      r_tail_data <= w_tail_data_nxt;
      r_tail_src  <= w_tail_src_nxt;
      r_err       <= w_err_nxt;
    end
  end

endmodule

// File: tb/tb_wb_select_buf.sv
// Bench for wb_select_buf: a default instance (3 x 8-bit) and a 4 x 16-bit
// instance, each compared every cycle against a queue-based reference model.
module tb_wb_select_buf;

  typedef struct packed {
    logic [15:0] d;
    logic [3:0]  s;
  } ent_t;

  logic clk = 1'b0;
  logic rst;

  // Instance A: NUM_IN=3, WIDTH=8
  logic [23:0] a_in;
  logic [1:0]  a_sel;
  logic        a_iv, a_ir, a_ov, a_or, a_fl, a_err, a_ec;
  logic [7:0]  a_od;
  logic [1:0]  a_os;

  // Instance B: NUM_IN=4, WIDTH=16
  logic [63:0] b_in;
  logic [1:0]  b_sel;
  logic        b_iv, b_ir, b_ov, b_or, b_fl, b_err, b_ec;
  logic [15:0] b_od;
  logic [1:0]  b_os;

  int   n_tests = 0;
  int   n_fail  = 0;
  ent_t qa[$];
  ent_t qb[$];
  logic ea, eb;

  always #5 clk = ~clk;

  wb_select_buf dut_a (
    .Clk(clk), .Reset(rst), .In(a_in), .Sel(a_sel), .InValid(a_iv), .InReady(a_ir),
    .OutData(a_od), .OutSrc(a_os), .OutValid(a_ov), .OutReady(a_or), .Flush(a_fl),
    .Err(a_err), .ErrClr(a_ec)
  );

  wb_select_buf #(.NUM_IN(4), .WIDTH(16)) dut_b (
    .Clk(clk), .Reset(rst), .In(b_in), .Sel(b_sel), .InValid(b_iv), .InReady(b_ir),
    .OutData(b_od), .OutSrc(b_os), .OutValid(b_ov), .OutReady(b_or), .Flush(b_fl),
    .Err(b_err), .ErrClr(b_ec)
  );

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, act, exp, $time);
    end
  endtask

  // Compare both instances against the model, advance the model with the
  // inputs currently applied, then step to just after the next rising edge.
  task automatic cycle();
    ent_t e;
    bit   acc, pop;
    chk("a_ready", 32'(a_ir),  32'(qa.size() < 2));
    chk("a_valid", 32'(a_ov),  32'(qa.size() != 0));
    chk("a_data",  32'(a_od),  (qa.size() != 0) ? 32'(qa[0].d) : 32'd0);
    chk("a_src",   32'(a_os),  (qa.size() != 0) ? 32'(qa[0].s) : 32'd0);
    chk("a_err",   32'(a_err), 32'(ea));
    chk("b_ready", 32'(b_ir),  32'(qb.size() < 2));
    chk("b_valid", 32'(b_ov),  32'(qb.size() != 0));
    chk("b_data",  32'(b_od),  (qb.size() != 0) ? 32'(qb[0].d) : 32'd0);
    chk("b_src",   32'(b_os),  (qb.size() != 0) ? 32'(qb[0].s) : 32'd0);
    chk("b_err",   32'(b_err), 32'(eb));

    if (rst) begin
      qa.delete(); ea = 1'b0;
      qb.delete(); eb = 1'b0;
    end else begin
      acc = a_iv && (qa.size() < 2);
      pop = a_or && (qa.size() != 0);
      e.s = 4'(a_sel);
      e.d = (a_sel < 2'd3) ? 16'((a_in >> (8 * int'(a_sel))) & 24'hFF) : 16'd0;
      if (acc && a_sel >= 2'd3) ea = 1'b1;
      else if (a_ec)            ea = 1'b0;
      if (a_fl) qa.delete();
      else begin
        if (pop) void'(qa.pop_front());
        if (acc) qa.push_back(e);
      end

      acc = b_iv && (qb.size() < 2);
      pop = b_or && (qb.size() != 0);
      e.s = 4'(b_sel);
      e.d = 16'((b_in >> (16 * int'(b_sel))) & 64'hFFFF);
      if (b_ec) eb = 1'b0;
      if (b_fl) qb.delete();
      else begin
        if (pop) void'(qb.pop_front());
        if (acc) qb.push_back(e);
      end
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    ea = 1'b0; eb = 1'b0;
    rst = 1'b1;
    a_in = 24'h332211; a_sel = 2'd0; a_iv = 1'b0; a_or = 1'b0; a_fl = 1'b0; a_ec = 1'b0;
    b_in = '0;         b_sel = 2'd0; b_iv = 1'b0; b_or = 1'b0; b_fl = 1'b0; b_ec = 1'b0;
    @(posedge clk); #1;
    cycle();
    rst = 1'b0;
    chk("rst_valid", 32'(a_ov), 32'd0);
    chk("rst_ready", 32'(a_ir), 32'd1);
    chk("rst_data",  32'(a_od), 32'd0);

    // Single accept, one-cycle latency
    a_sel = 2'd1; a_iv = 1'b1; a_or = 1'b1;
    cycle();
    a_iv = 1'b0;
    chk("single_valid", 32'(a_ov), 32'd1);
    chk("single_data",  32'(a_od), 32'h22);
    chk("single_src",   32'(a_os), 32'd1);
    cycle();
    chk("single_drained", 32'(a_ov), 32'd0);
    chk("single_zero",    32'(a_od), 32'd0);

    // Back-pressure: fill, hold a third offer, then drain in order
    a_or = 1'b0; a_sel = 2'd0; a_iv = 1'b1;
    cycle();
    a_sel = 2'd2;
    cycle();
    chk("full_ready", 32'(a_ir), 32'd0);
    a_sel = 2'd1;
    cycle();
    cycle();
    chk("full_hold", 32'(a_od), 32'h11);
    a_or = 1'b1;
    cycle();
    chk("drain_2nd", 32'(a_od), 32'h33);
    cycle();
    a_iv = 1'b0;
    chk("drain_3rd", 32'(a_od), 32'h22);
    cycle();
    chk("drain_empty", 32'(a_ov), 32'd0);

    // Illegal select: zero data, source kept, sticky error
    a_or = 1'b0; a_sel = 2'd3; a_iv = 1'b1;
    cycle();
    a_iv = 1'b0;
    chk("illegal_data", 32'(a_od),  32'd0);
    chk("illegal_src",  32'(a_os),  32'd3);
    chk("illegal_err",  32'(a_err), 32'd1);
    cycle();
    cycle();
    chk("err_sticky", 32'(a_err), 32'd1);
    a_ec = 1'b1;
    cycle();
    a_ec = 1'b0;
    chk("err_clear", 32'(a_err), 32'd0);
    a_or = 1'b1; a_ec = 1'b1; a_iv = 1'b1; a_sel = 2'd3;
    cycle();
    a_ec = 1'b0; a_iv = 1'b0;
    chk("err_set_wins", 32'(a_err), 32'd1);
    cycle();
    cycle();

    // Push and pop together at count 1
    a_or = 1'b0; a_sel = 2'd0; a_iv = 1'b1;
    cycle();
    a_or = 1'b1; a_sel = 2'd2;
    cycle();
    a_iv = 1'b0;
    chk("pushpop_data",  32'(a_od), 32'h33);
    chk("pushpop_ready", 32'(a_ir), 32'd1);
    chk("pushpop_valid", 32'(a_ov), 32'd1);
    cycle();

    // Flush while full with an offer pending; error untouched
    a_or = 1'b0; a_iv = 1'b1; a_sel = 2'd0;
    cycle();
    a_sel = 2'd2;
    cycle();
    a_fl = 1'b1; a_sel = 2'd1;
    cycle();
    a_fl = 1'b0; a_iv = 1'b0;
    chk("flush_valid", 32'(a_ov),  32'd0);
    chk("flush_ready", 32'(a_ir),  32'd1);
    chk("flush_err",   32'(a_err), 32'd1);
    cycle();

    // Reset mid-stream also clears the error
    a_iv = 1'b1; a_sel = 2'd0;
    cycle();
    cycle();
    rst = 1'b1; a_fl = 1'b1; a_or = 1'b1; a_ec = 1'b0;
    cycle();
    rst = 1'b0; a_fl = 1'b0; a_iv = 1'b0;
    chk("rst_mid_valid", 32'(a_ov),  32'd0);
    chk("rst_mid_err",   32'(a_err), 32'd0);
    chk("rst_mid_ready", 32'(a_ir),  32'd1);

    // Random streaming on both instances
    for (int i = 0; i < 600; i++) begin
      a_in  = 24'($urandom);
      a_sel = 2'($urandom_range(0, 3));
      a_iv  = 1'($urandom_range(0, 3) != 0);
      a_or  = 1'($urandom_range(0, 1));
      a_fl  = 1'($urandom_range(0, 15) == 0);
      a_ec  = 1'($urandom_range(0, 7) == 0);
      b_in  = {32'($urandom), 32'($urandom)};
      b_sel = 2'($urandom_range(0, 3));
      b_iv  = 1'($urandom_range(0, 3) != 0);
      b_or  = 1'($urandom_range(0, 2) != 0);
      b_fl  = 1'($urandom_range(0, 31) == 0);
      b_ec  = 1'($urandom_range(0, 15) == 0);
      cycle();
    end
    a_iv = 1'b0; b_iv = 1'b0; a_or = 1'b1; b_or = 1'b1; a_fl = 1'b0; b_fl = 1'b0;
    cycle();
    cycle();
    cycle();
    chk("b_err_never", 32'(b_err), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
